// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle IF/ID/EXE/MEM/WB sequencer for the MIPS-subset datapath
// Decodes OP/func into an instruction class, then drives datapath selects per phase.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OP,
  input  logic [5:0]       func,
  input  logic             ZF,
  output logic             PC_Write,
  output logic [1:0]       PC_s,
  output logic             IR_Write,
  output logic             Write_Reg,
  output logic             Mem_Write,
  output logic [1:0]       w_r_s,
  output logic [1:0]       wr_data_s,
  output logic             imm_s,
  output logic             rt_imm_s,
  output logic [2:0]       ALU_OP,
  output logic [2:0]       state,
  output logic             inst_done,
  output logic             illegal,
  output logic [CNT_W-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EXE = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_t;

  typedef enum logic [3:0] {
    C_RALU, C_JR, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_ILL
  } cls_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  cls_t       cls;
  logic [2:0] alu_dec;
  logic       sext_dec;

  logic       pcw_r, irw_r, wreg_r, memw_r, done_r, ill_r, imm_r, rti_r;
  logic [1:0] pcs_r, wrs_r, wds_r;
  logic [2:0] alu_r;

  always_comb begin
    cls      = C_ILL;
    alu_dec  = ALU_AND;
    sext_dec = 1'b0;
    case (OP)
      6'b000000: begin
        cls = C_RALU;
        case (func)
          6'b100000: alu_dec = ALU_ADD;
          6'b100010: alu_dec = ALU_SUB;
          6'b100100: alu_dec = ALU_AND;
          6'b100101: alu_dec = ALU_OR;
          6'b100110: alu_dec = ALU_XOR;
          6'b100111: alu_dec = ALU_NOR;
          6'b101010: alu_dec = ALU_SLT;
          6'b000100: alu_dec = ALU_SLL;
          6'b001000: cls = C_JR;
          default:   cls = C_ILL;
        endcase
      end
      6'b001000: begin cls = C_IALU; alu_dec = ALU_ADD; sext_dec = 1'b1; end
      6'b001100: begin cls = C_IALU; alu_dec = ALU_AND; end
      6'b001101: begin cls = C_IALU; alu_dec = ALU_OR;  end
      6'b001110: begin cls = C_IALU; alu_dec = ALU_XOR; end
      6'b100011: begin cls = C_LW;   alu_dec = ALU_ADD; sext_dec = 1'b1; end
      6'b101011: begin cls = C_SW;   alu_dec = ALU_ADD; sext_dec = 1'b1; end
      6'b000100: begin cls = C_BEQ;  alu_dec = ALU_SUB; sext_dec = 1'b1; end
      6'b000101: begin cls = C_BNE;  alu_dec = ALU_SUB; sext_dec = 1'b1; end
      6'b000010: cls = C_J;
      6'b000011: cls = C_JAL;
      default:   cls = C_ILL;
    endcase
  end

  always_comb begin
    state_d = S_IF;
    pcw_r   = 1'b0;
    irw_r   = 1'b0;
    wreg_r  = 1'b0;
    memw_r  = 1'b0;
    done_r  = 1'b0;
    ill_r   = 1'b0;
    imm_r   = 1'b0;
    rti_r   = 1'b0;
    pcs_r   = 2'b00;
    wrs_r   = 2'b00;
    wds_r   = 2'b00;
    alu_r   = ALU_AND;
    case (state_q)
      S_IF: begin
        irw_r   = 1'b1;
        pcw_r   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        case (cls)
          C_J: begin
            pcw_r  = 1'b1;
            pcs_r  = 2'b11;
            done_r = 1'b1;
          end
          // PC_new already holds PC+4, so the link value is ready here.
          C_JAL: begin
            pcw_r  = 1'b1;
            pcs_r  = 2'b11;
            wreg_r = 1'b1;
            wrs_r  = 2'b10;
            wds_r  = 2'b10;
            done_r = 1'b1;
          end
          C_ILL: begin
            ill_r  = 1'b1;
            done_r = 1'b1;
          end
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        case (cls)
          C_RALU: begin
            alu_r   = alu_dec;
            state_d = S_WB;
          end
          C_JR: begin
            pcw_r  = 1'b1;
            pcs_r  = 2'b01;
            done_r = 1'b1;
          end
          C_IALU: begin
            alu_r   = alu_dec;
            imm_r   = sext_dec;
            rti_r   = 1'b1;
            state_d = S_WB;
          end
          C_LW, C_SW: begin
            alu_r   = alu_dec;
            imm_r   = 1'b1;
            rti_r   = 1'b1;
            state_d = S_MEM;
          end
          C_BEQ, C_BNE: begin
            alu_r  = alu_dec;
            pcs_r  = 2'b10;
            imm_r  = 1'b1;
            pcw_r  = (cls == C_BEQ) ? ZF : ~ZF;
            done_r = 1'b1;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        // Keep the effective address on the ALU output while the RAM is accessed.
        alu_r = ALU_ADD;
        imm_r = 1'b1;
        rti_r = 1'b1;
        case (cls)
          C_SW: begin
            memw_r = 1'b1;
            done_r = 1'b1;
          end
          C_LW:    state_d = S_WB;
          default: state_d = S_IF;
        endcase
      end
      S_WB: begin
        done_r = 1'b1;
        case (cls)
          C_RALU: begin
            wreg_r = 1'b1;
            alu_r  = alu_dec;
          end
          C_IALU: begin
            wreg_r = 1'b1;
            wrs_r  = 2'b01;
            alu_r  = alu_dec;
            imm_r  = sext_dec;
            rti_r  = 1'b1;
          end
          C_LW: begin
            wreg_r = 1'b1;
            wrs_r  = 2'b01;
            wds_r  = 2'b01;
          end
          default: wreg_r = 1'b0;
        endcase
      end
      default: state_d = S_IF;
    endcase
  end

  assign cnt_d = done_r ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset overrides every decoded output so an aborted instruction cannot write.
  assign PC_Write  = pcw_r  & ~rst;
  assign IR_Write  = irw_r  & ~rst;
  assign Write_Reg = wreg_r & ~rst;
  assign Mem_Write = memw_r & ~rst;
  assign inst_done = done_r & ~rst;
  assign illegal   = ill_r  & ~rst;
  assign imm_s     = imm_r  & ~rst;
  assign rt_imm_s  = rti_r  & ~rst;
  assign PC_s      = rst ? 2'b00 : pcs_r;
  assign w_r_s     = rst ? 2'b00 : wrs_r;
  assign wr_data_s = rst ? 2'b00 : wds_r;
  assign ALU_OP    = rst ? 3'b000 : alu_r;
  assign state     = state_q;
  assign inst_cnt  = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed table, reset/wrap sequences and random stream for multicycle_ctrl
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_s;
    logic       ir_write;
    logic       write_reg;
    logic       mem_write;
    logic [1:0] w_r_s;
    logic [1:0] wr_data_s;
    logic       imm_s;
    logic       rt_imm_s;
    logic [2:0] alu_op;
    logic [2:0] state;
    logic       inst_done;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zf;
    int         lat;
    logic       pcw;
    logic       wreg;
    logic [1:0] wrs;
    logic [1:0] wds;
    logic       mw;
    logic [2:0] alu;
    logic       ill;
  } vec_t;

  localparam int K_RALU = 0, K_JR = 1, K_IALU = 2, K_LW = 3, K_SW = 4;
  localparam int K_BEQ = 5, K_BNE = 6, K_J = 7, K_JAL = 8, K_ILL = 9;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] OP, func;
  logic ZF;

  logic pcw, irw, wreg, memw, imms, rtis, done, ill;
  logic [1:0] pcs, wrs, wds;
  logic [2:0] alu, st;
  logic [31:0] cnt;

  logic pcw4, irw4, wreg4, memw4, imms4, rtis4, done4, ill4;
  logic [1:0] pcs4, wrs4, wds4;
  logic [2:0] alu4, st4;
  logic [3:0] cnt4;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_cnt;

  logic [5:0] rfuncs [9]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                              6'b100111, 6'b101010, 6'b000100, 6'b001000};
  logic [5:0] iops   [10] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b100011,
                              6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011};

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .OP(OP), .func(func), .ZF(ZF),
    .PC_Write(pcw), .PC_s(pcs), .IR_Write(irw), .Write_Reg(wreg), .Mem_Write(memw),
    .w_r_s(wrs), .wr_data_s(wds), .imm_s(imms), .rt_imm_s(rtis), .ALU_OP(alu),
    .state(st), .inst_done(done), .illegal(ill), .inst_cnt(cnt)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .OP(OP), .func(func), .ZF(ZF),
    .PC_Write(pcw4), .PC_s(pcs4), .IR_Write(irw4), .Write_Reg(wreg4), .Mem_Write(memw4),
    .w_r_s(wrs4), .wr_data_s(wds4), .imm_s(imms4), .rt_imm_s(rtis4), .ALU_OP(alu4),
    .state(st4), .inst_done(done4), .illegal(ill4), .inst_cnt(cnt4)
  );

  function automatic outs_t s32();
    return {pcw, pcs, irw, wreg, memw, wrs, wds, imms, rtis, alu, st, done, ill};
  endfunction

  function automatic outs_t s4();
    return {pcw4, pcs4, irw4, wreg4, memw4, wrs4, wds4, imms4, rtis4, alu4, st4, done4, ill4};
  endfunction

  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b001000) return K_JR;
        foreach (rfuncs[i]) if (i < 8 && rfuncs[i] == fn) return K_RALU;
        return K_ILL;
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001110: return K_IALU;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000101: return K_BNE;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
    logic [2:0] rcode [8] = '{3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    if (op == 6'b000000) begin
      foreach (rcode[i]) if (rfuncs[i] == fn) return rcode[i];
      return 3'd0;
    end
    case (op)
      6'b001100: return 3'd0;
      6'b001101: return 3'd1;
      6'b001110: return 3'd2;
      6'b000100, 6'b000101: return 3'd5;
      default:   return 3'd4;
    endcase
  endfunction

  function automatic int lat_of(input int kd);
    if (kd == K_J || kd == K_JAL || kd == K_ILL) return 2;
    if (kd == K_JR || kd == K_BEQ || kd == K_BNE) return 3;
    if (kd == K_LW) return 5;
    return 4;
  endfunction

  // Expected outputs on cycle k (0 = fetch) of one instruction.
  function automatic outs_t model(input logic [5:0] op, input logic [5:0] fn, input logic zf, input int k);
    outs_t o = '0;
    int kd = kind_of(op, fn);
    int n = lat_of(kd);
    bit mem = (kd == K_LW || kd == K_SW);
    bit is_exe = (k == 2);
    bit is_mem = (k == 3 && mem);
    bit is_wb = !is_exe && !is_mem;
    o.state = (k <= 2) ? 3'(k) : (is_mem ? 3'd3 : 3'd4);
    o.inst_done = (k == n - 1);
    if (k == 0) begin
      o.ir_write = 1'b1;
      o.pc_write = 1'b1;
    end else if (k == 1) begin
      if (kd == K_J || kd == K_JAL) begin o.pc_write = 1'b1; o.pc_s = 2'b11; end
      if (kd == K_JAL) begin o.write_reg = 1'b1; o.w_r_s = 2'b10; o.wr_data_s = 2'b10; end
      if (kd == K_ILL) o.illegal = 1'b1;
    end else begin
      case (kd)
        K_RALU: begin
          o.alu_op = alu_of(op, fn);
          o.write_reg = is_wb;
        end
        K_JR: begin o.pc_write = 1'b1; o.pc_s = 2'b01; end
        K_IALU: begin
          o.alu_op = alu_of(op, fn);
          o.imm_s = (op == 6'b001000);
          o.rt_imm_s = 1'b1;
          if (is_wb) begin o.write_reg = 1'b1; o.w_r_s = 2'b01; end
        end
        K_LW, K_SW: begin
          if (is_wb) begin
            o.write_reg = 1'b1; o.w_r_s = 2'b01; o.wr_data_s = 2'b01;
          end else begin
            o.alu_op = 3'd4; o.imm_s = 1'b1; o.rt_imm_s = 1'b1;
            o.mem_write = is_mem && kd == K_SW;
          end
        end
        K_BEQ, K_BNE: begin
          o.alu_op = 3'd5; o.pc_s = 2'b10; o.imm_s = 1'b1;
          o.pc_write = (kd == K_BEQ) ? zf : !zf;
        end
        default: o = o;
      endcase
    end
    return o;
  endfunction

  task automatic check(input string nm, input int k, input outs_t got, input outs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s op=%b func=%b cycle=%0d got=%h expected=%h", nm, OP, func, k, got, exp);
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // zf_mode 0/1 holds ZF fixed, 2 randomises it every cycle.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int zf_mode,
                          output int cycles, output outs_t last);
    cycles = 0;
    last = '0;
    OP = op;
    func = fn;
    for (int k = 0; k < 8; k++) begin
      ZF = (zf_mode == 2) ? 1'($urandom_range(0, 1)) : zf_mode[0];
      @(negedge clk);
      check("cycle32", k, s32(), model(op, fn, ZF, k));
      check("cycle4", k, s4(), model(op, fn, ZF, k));
      last = s32();
      @(posedge clk);
      #1;
      if (last.inst_done) begin
        cycles = k + 1;
        break;
      end
    end
    tests++;
    if (cycles == 0) begin
      fails++;
      $display("FAIL retire_timeout op=%b func=%b got=none expected=inst_done", op, fn);
    end
    model_cnt = model_cnt + 32'd1;
    check_val("inst_cnt32", cnt, model_cnt);
    check_val("inst_cnt4", {28'd0, cnt4}, {28'd0, model_cnt[3:0]});
  endtask

  function automatic vec_t mkv(input logic [5:0] op, input logic [5:0] fn, input logic zf, input int lat,
                               input logic pcw_e, input logic wreg_e, input logic [1:0] wrs_e,
                               input logic [1:0] wds_e, input logic mw_e, input logic [2:0] alu_e,
                               input logic ill_e);
    vec_t v;
    v.op = op; v.fn = fn; v.zf = zf; v.lat = lat;
    v.pcw = pcw_e; v.wreg = wreg_e; v.wrs = wrs_e; v.wds = wds_e;
    v.mw = mw_e; v.alu = alu_e; v.ill = ill_e;
    return v;
  endfunction

  initial begin
    vec_t  vt[$];
    int    cyc;
    outs_t lst;

    //                 op         fn         zf   lat pcw wreg wrs    wds    mw  alu     ill
    vt.push_back(mkv(6'b000000, 6'b100000, 1'b0, 4, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b100, 1'b0));
    vt.push_back(mkv(6'b000000, 6'b100010, 1'b0, 4, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b101, 1'b0));
    vt.push_back(mkv(6'b000000, 6'b100100, 1'b0, 4, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0));
    vt.push_back(mkv(6'b000000, 6'b100101, 1'b0, 4, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0));
    vt.push_back(mkv(6'b000000, 6'b100110, 1'b0, 4, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b010, 1'b0));
    vt.push_back(mkv(6'b000000, 6'b100111, 1'b0, 4, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b011, 1'b0));
    vt.push_back(mkv(6'b000000, 6'b101010, 1'b0, 4, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b110, 1'b0));
    vt.push_back(mkv(6'b000000, 6'b000100, 1'b0, 4, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b111, 1'b0));
    vt.push_back(mkv(6'b000000, 6'b001000, 1'b0, 3, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0));
    vt.push_back(mkv(6'b001000, 6'b000000, 1'b0, 4, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 3'b100, 1'b0));
    vt.push_back(mkv(6'b001100, 6'b000000, 1'b0, 4, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0));
    vt.push_back(mkv(6'b001101, 6'b000000, 1'b0, 4, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 3'b001, 1'b0));
    vt.push_back(mkv(6'b001110, 6'b000000, 1'b0, 4, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0));
    vt.push_back(mkv(6'b100011, 6'b000000, 1'b0, 5, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 3'b000, 1'b0));
    vt.push_back(mkv(6'b101011, 6'b000000, 1'b0, 4, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 3'b100, 1'b0));
    vt.push_back(mkv(6'b000100, 6'b000000, 1'b1, 3, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b101, 1'b0));
    vt.push_back(mkv(6'b000100, 6'b000000, 1'b0, 3, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b101, 1'b0));
    vt.push_back(mkv(6'b000101, 6'b000000, 1'b0, 3, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b101, 1'b0));
    vt.push_back(mkv(6'b000101, 6'b000000, 1'b1, 3, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b101, 1'b0));
    vt.push_back(mkv(6'b000010, 6'b000000, 1'b0, 2, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0));
    vt.push_back(mkv(6'b000011, 6'b000000, 1'b0, 2, 1'b1, 1'b1, 2'b10, 2'b10, 1'b0, 3'b000, 1'b0));
    vt.push_back(mkv(6'b111111, 6'b000000, 1'b0, 2, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b1));
    vt.push_back(mkv(6'b000000, 6'b111111, 1'b0, 2, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b1));

    rst = 1'b1;
    OP = 6'd0;
    func = 6'd0;
    ZF = 1'b0;
    model_cnt = 32'd0;
    @(negedge clk);
    check("reset32", 0, s32(), '0);
    check("reset4", 0, s4(), '0);
    check_val("reset_cnt32", cnt, 32'd0);
    check_val("reset_cnt4", {28'd0, cnt4}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vt[i]) begin
      do_instr(vt[i].op, vt[i].fn, int'(vt[i].zf), cyc, lst);
      check_val("latency", cyc, vt[i].lat);
      tests++;
      if ({lst.pc_write, lst.write_reg, lst.w_r_s, lst.wr_data_s, lst.mem_write, lst.alu_op, lst.illegal}
          !== {vt[i].pcw, vt[i].wreg, vt[i].wrs, vt[i].wds, vt[i].mw, vt[i].alu, vt[i].ill}) begin
        fails++;
        $display("FAIL last_cycle op=%b func=%b got=%h expected=%b%b%b%b%b%b%b", vt[i].op, vt[i].fn, lst,
                 vt[i].pcw, vt[i].wreg, vt[i].wrs, vt[i].wds, vt[i].mw, vt[i].alu, vt[i].ill);
      end
    end

    // Abort an add in EXE: reset must clear state at once and block the WB write.
    OP = 6'b000000;
    func = 6'b100000;
    ZF = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("pre_reset", k, s32(), model(OP, func, ZF, k));
      if (k < 2) begin
        @(posedge clk);
        #1;
      end
    end
    #2 rst = 1'b1;
    #1;
    check("reset_async", 2, s32(), '0);
    @(posedge clk);
    #1;
    check("reset_hold", 3, s32(), '0);
    model_cnt = 32'd0;
    check_val("abort_cnt32", cnt, 32'd0);
    check_val("abort_cnt4", {28'd0, cnt4}, 32'd0);
    rst = 1'b0;
    do_instr(6'b000000, 6'b100000, 0, cyc, lst);
    check_val("restart_latency", cyc, 4);

    // Random stream; the 4-bit counter wraps several times along the way.
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [5:0] op, fn;
      r = $urandom_range(0, 20);
      fn = 6'($urandom);
      if (r <= 8) begin
        op = 6'b000000;
        fn = rfuncs[r];
      end else if (r == 9) begin
        op = 6'b000000;
      end else if (r <= 19) begin
        op = iops[r - 10];
      end else begin
        op = 6'($urandom);
      end
      do_instr(op, fn, 2, cyc, lst);
    end
    check_val("wrapped_cnt4", {28'd0, cnt4}, {28'd0, model_cnt[3:0]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
